// File: rtl/intr_ctrl.sv
// Interrupt controller: latches external sources into pending bits, masks them, and sequences
// one fixed-priority request at a time through request -> trap-taken -> mret.
module intr_ctrl #(
    parameter int N_SRC = 4,
    parameter int ID_W  = $clog2(N_SRC),
    parameter bit EDGE  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             en_we,
    input  logic [N_SRC-1:0] en_wdata,
    input  logic             mie,
    input  logic             intr_ack,
    input  logic             mret,
    output logic             intrrupt,
    output logic [ID_W-1:0]  intr_id,
    output logic [N_SRC-1:0] en_mask,
    output logic [N_SRC-1:0] pending,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t           state;
    logic [N_SRC-1:0] srcPrev;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] ackClear;
    logic [N_SRC-1:0] pendingNext;
    logic [ID_W-1:0]  winner;
    logic             anyEligible;
    logic             curEligible;

    assign eligible    = pending & en_mask;
    assign anyEligible = |eligible;
    assign curEligible = eligible[intr_id];

    // Scan from the top so the lowest-index eligible source is the final assignment.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        ackClear = '0;
        if (state == REQ && intr_ack) begin
            ackClear[intr_id] = 1'b1;
        end
    end

    // The set term is OR-ed after the clear so a fresh edge coinciding with its own ack survives.
    assign pendingNext = EDGE ? ((pending & ~ackClear) | (irq_src & ~srcPrev)) : irq_src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srcPrev <= '0;
            pending <= '0;
            en_mask <= '0;
        end else begin
            srcPrev <= irq_src;
            pending <= pendingNext;
            if (en_we) begin
                en_mask <= en_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            intrrupt <= 1'b0;
            intr_id  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mie && anyEligible) begin
                        state    <= REQ;
                        intrrupt <= 1'b1;
                        intr_id  <= winner;
                    end
                end
                REQ: begin
                    // intr_id stays frozen here; a taken trap beats a simultaneous withdraw.
                    if (intr_ack) begin
                        state    <= SERVICE;
                        intrrupt <= 1'b0;
                        busy     <= 1'b1;
                    end else if (!mie || !curEligible) begin
                        state    <= IDLE;
                        intrrupt <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (mret) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    intrrupt <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model.
module tb_intr_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq_src;
    logic       en_we;
    logic [3:0] en_wdata;
    logic       mie;
    logic       intr_ack;
    logic       mret;
    logic       intrrupt;
    logic [1:0] intr_id;
    logic [3:0] en_mask;
    logic [3:0] pending;
    logic       busy;

    int checks = 0;
    int errors = 0;

    intr_ctrl #(.N_SRC(4), .ID_W(2), .EDGE(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_src  (irq_src),
        .en_we    (en_we),
        .en_wdata (en_wdata),
        .mie      (mie),
        .intr_ack (intr_ack),
        .mret     (mret),
        .intrrupt (intrrupt),
        .intr_id  (intr_id),
        .en_mask  (en_mask),
        .pending  (pending),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: requesting / in-service flags and a pending set.
    logic [3:0] mPend, mEn, mPrev, mElig, mKept;
    logic       mReq, mSvc;
    int         mId;

    function automatic int lowestSet(input logic [3:0] v);
        logic [3:0] iso;
        iso = v & (~v + 4'd1);
        return $clog2(int'(iso));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPend = 4'd0; mEn = 4'd0; mPrev = 4'd0;
            mReq = 1'b0; mSvc = 1'b0; mId = 0;
        end else begin
            mElig = mPend & mEn;
            mKept = mPend;
            if (mReq && intr_ack) mKept[mId] = 1'b0;
            if (mSvc) begin
                if (mret) mSvc = 1'b0;
            end else if (mReq) begin
                if (intr_ack) begin
                    mReq = 1'b0;
                    mSvc = 1'b1;
                end else if (!mie || !mElig[mId]) begin
                    mReq = 1'b0;
                end
            end else if (mie && mElig != 4'd0) begin
                mReq = 1'b1;
                mId  = lowestSet(mElig);
            end
            mPend = mKept | (irq_src & ~mPrev);
            mPrev = irq_src;
            if (en_we) mEn = en_wdata;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; irq_src = 4'd0; en_we = 1'b0; en_wdata = 4'd0;
        mie = 1'b0; intr_ack = 1'b0; mret = 1'b0;
        tick(2);
        checks++;
        if (intrrupt !== 1'b0) begin errors++; $display("[TB] FAIL reset_intrrupt got %0b want 0", intrrupt); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        checks++;
        if (pending !== 4'd0) begin errors++; $display("[TB] FAIL reset_pending got %b want 0000", pending); end
        checks++;
        if (en_mask !== 4'd0) begin errors++; $display("[TB] FAIL reset_en_mask got %b want 0000", en_mask); end
        checks++;
        if (intr_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_intr_id got %0d want 0", intr_id); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_pulse;
        en_we = 1'b1; en_wdata = 4'hF; mie = 1'b1;
        tick();
        en_we = 1'b0; irq_src = 4'b0100;
        tick();
        irq_src = 4'd0;
        checks++;
        if (pending !== 4'b0100 || intrrupt !== 1'b0) begin
            errors++; $display("[TB] FAIL pulse_pending got pend=%b irq=%0b want 0100/0", pending, intrrupt);
        end
        tick();
        checks++;
        if (intrrupt !== 1'b1 || intr_id !== 2'd2) begin
            errors++; $display("[TB] FAIL pulse_request got irq=%0b id=%0d want 1/2", intrrupt, intr_id);
        end
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        checks++;
        if (pending !== 4'd0 || busy !== 1'b1 || intrrupt !== 1'b0) begin
            errors++; $display("[TB] FAIL pulse_ack got pend=%b busy=%0b irq=%0b want 0000/1/0", pending, busy, intrrupt);
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || intrrupt !== 1'b0) begin
            errors++; $display("[TB] FAIL pulse_mret got busy=%0b irq=%0b want 0/0", busy, intrrupt);
        end
    endtask

    task automatic test_priority;
        irq_src = 4'b1010;
        tick();
        irq_src = 4'd0;
        tick();
        checks++;
        if (intrrupt !== 1'b1 || intr_id !== 2'd1) begin
            errors++; $display("[TB] FAIL prio_first got irq=%0b id=%0d want 1/1", intrrupt, intr_id);
        end
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        checks++;
        if (pending !== 4'b1000 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL prio_ack got pend=%b busy=%0b want 1000/1", pending, busy);
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        checks++;
        if (intrrupt !== 1'b0) begin errors++; $display("[TB] FAIL prio_mret_early got irq=%0b want 0", intrrupt); end
        tick();
        checks++;
        if (intrrupt !== 1'b1 || intr_id !== 2'd3) begin
            errors++; $display("[TB] FAIL prio_second got irq=%0b id=%0d want 1/3", intrrupt, intr_id);
        end
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0; mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic test_mask;
        int quiet;
        en_we = 1'b1; en_wdata = 4'b0111;
        tick();
        en_we = 1'b0; irq_src = 4'b1000;
        tick();
        irq_src = 4'd0;
        checks++;
        if (pending[3] !== 1'b1) begin errors++; $display("[TB] FAIL mask_pending got %b want 1xxx", pending); end
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (intrrupt === 1'b0) quiet++;
        end
        checks++;
        if (quiet != 10) begin errors++; $display("[TB] FAIL mask_quiet got %0d quiet cycles want 10", quiet); end
        en_we = 1'b1; en_wdata = 4'b1000;
        tick();
        en_we = 1'b0;
        tick();
        checks++;
        if (intrrupt !== 1'b1 || intr_id !== 2'd3) begin
            errors++; $display("[TB] FAIL mask_unmask got irq=%0b id=%0d want 1/3", intrrupt, intr_id);
        end
    endtask

    task automatic test_mie_withdraw;
        mie = 1'b0;
        tick();
        checks++;
        if (intrrupt !== 1'b0 || pending !== 4'b1000) begin
            errors++; $display("[TB] FAIL withdraw got irq=%0b pend=%b want 0/1000", intrrupt, pending);
        end
        mie = 1'b1;
        tick();
        checks++;
        if (intrrupt !== 1'b1 || intr_id !== 2'd3) begin
            errors++; $display("[TB] FAIL rerequest got irq=%0b id=%0d want 1/3", intrrupt, intr_id);
        end
        intr_ack = 1'b1; en_we = 1'b1; en_wdata = 4'hF;
        tick();
        intr_ack = 1'b0; en_we = 1'b0; mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
    endtask

    task automatic test_ack_collision;
        irq_src = 4'b0001;
        tick();
        irq_src = 4'd0;
        tick();
        checks++;
        if (intrrupt !== 1'b1 || intr_id !== 2'd0) begin
            errors++; $display("[TB] FAIL coll_req got irq=%0b id=%0d want 1/0", intrrupt, intr_id);
        end
        intr_ack = 1'b1; irq_src = 4'b0001;
        tick();
        intr_ack = 1'b0; irq_src = 4'd0;
        checks++;
        if (pending[0] !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL coll_keep got pend=%b busy=%0b want xxx1/1", pending, busy);
        end
        tick();
        checks++;
        if (intrrupt !== 1'b0) begin errors++; $display("[TB] FAIL coll_nonest got irq=%0b want 0", intrrupt); end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
        checks++;
        if (intrrupt !== 1'b1 || intr_id !== 2'd0) begin
            errors++; $display("[TB] FAIL coll_again got irq=%0b id=%0d want 1/0", intrrupt, intr_id);
        end
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0; mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic test_reset_in_service;
        irq_src = 4'b0100;
        tick();
        irq_src = 4'd0;
        tick();
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0; irq_src = 4'b0010;
        tick();
        irq_src = 4'd0;
        checks++;
        if (busy !== 1'b1 || pending !== 4'b0010) begin
            errors++; $display("[TB] FAIL svc_setup got busy=%0b pend=%b want 1/0010", busy, pending);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || intrrupt !== 1'b0 || pending !== 4'd0 || en_mask !== 4'd0) begin
            errors++; $display("[TB] FAIL async_reset got busy=%0b irq=%0b pend=%b en=%b want 0/0/0000/0000",
                               busy, intrrupt, pending, en_mask);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_random;
        int bad;
        bad = 0;
        en_we = 1'b1; en_wdata = 4'hF; mie = 1'b1;
        tick();
        for (int i = 0; i < 400; i++) begin
            irq_src  = 4'($urandom);
            mie      = ($urandom_range(0, 7) != 0);
            en_we    = ($urandom_range(0, 15) == 0);
            en_wdata = 4'($urandom);
            intr_ack = ($urandom_range(0, 2) == 0);
            mret     = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (intrrupt !== mReq || busy !== mSvc || pending !== mPend || en_mask !== mEn ||
                (mReq && int'(intr_id) != mId)) begin
                errors++;
                if (bad < 5) begin
                    $display("[TB] FAIL random_cycle%0d got irq=%0b busy=%0b pend=%b en=%b id=%0d want %0b/%0b/%b/%b/%0d",
                             i, intrrupt, busy, pending, en_mask, intr_id, mReq, mSvc, mPend, mEn, mId);
                end
                bad++;
            end
        end
        irq_src = 4'd0; en_we = 1'b0; intr_ack = 1'b0; mret = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_priority();
        test_mask();
        test_mie_withdraw();
        test_ack_collision();
        test_reset_in_service();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
